// File: rtl/nand_unit_arbiter_pkg.sv
// Shared encodings for the NAND unit arbiter.
// Op select codes and controller state codes.
package nand_unit_arbiter_pkg;

    localparam logic OP_NAND = 1'b0;
    localparam logic OP_AND  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nand_unit_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or after ptr.
// Ports: req, ptr in; found, id out (combinational).
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   id
);

    // Scan downward so the lowest offset from ptr is written last.
    always_comb begin
        int idx;
        found = 1'b0;
        id    = '0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                found = 1'b1;
                id    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/nand_unit_arbiter.sv
// Round-robin sequencer sharing one WIDTH-bit NAND unit among NREQ clients.
// Ports: clk, rst_n, req/op/a_in/b_in in; gnt, busy, resp_valid/id/data out.
module nand_unit_arbiter
    import nand_unit_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           op,
    input  logic [NREQ*WIDTH-1:0]     a_in,
    input  logic [NREQ*WIDTH-1:0]     b_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      resp_valid,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [WIDTH-1:0]          resp_data
);

    localparam int IW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q;
    logic             op_q;
    logic [IW-1:0]    id_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic             found;
    logic [IW-1:0]    pick_id;
    logic             capture;
    logic [NREQ-1:0]  gnt_d;
    logic             busy_d, rv_d;
    logic [WIDTH-1:0] nx, nz, ny;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .id    (pick_id)
    );

    assign capture = (state_q == IDLE) && found;

    // Second AND pass feeds the accumulator to both gate inputs.
    assign nx = (state_q == PASS2) ? acc_q : a_q;
    assign nz = (state_q == PASS2) ? acc_q : b_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_nand
        nand u_nand (ny[i], nx[i], nz[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = PASS1;
            PASS1:   state_d = (op_q == OP_AND) ? PASS2 : DONE;
            PASS2:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response lands the cycle after DONE; busy covers that cycle too.
    always_comb begin
        gnt_d  = '0;
        if (capture) gnt_d = NREQ'(1) << pick_id;
        busy_d = (state_d != IDLE) || (state_q == DONE);
        rv_d   = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            op_q       <= OP_NAND;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            gnt        <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            gnt        <= gnt_d;
            busy       <= busy_d;
            resp_valid <= rv_d;
            if (capture) begin
                op_q  <= op[pick_id];
                id_q  <= pick_id;
                a_q   <= a_in[pick_id*WIDTH +: WIDTH];
                b_q   <= b_in[pick_id*WIDTH +: WIDTH];
                ptr_q <= (pick_id == IW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
            end
            if (state_q == PASS1 || state_q == PASS2) acc_q <= ny;
            if (state_q == DONE) begin
                resp_id   <= id_q;
                resp_data <= acc_q;
            end
        end
    end

endmodule
